k_phase_2b: RTL and testbench

//  - Phase-shift stage for stochastic bitstreams: circularly rotates a

---
 rtl/k_phase_2b.sv | 80 ++++++++
 tb/tb_k_phase_2b.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/k_phase_2b.sv
// Registered bitstream phase shifter: rotates a BITSTREAM-wide word by 0..3 bits, one word per cycle.
// Optional macro K_PHASE_BIDIR_EN adds a `dir` input selecting right rotation when high.
module k_phase_2b #(
    parameter int BITSTREAM = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [1:0]           k,
    input  logic [BITSTREAM-1:0] in_bits,
`ifdef K_PHASE_BIDIR_EN
    input  logic                 dir,
`endif
    output logic                 out_valid,
    output logic [BITSTREAM-1:0] out_bits
);

    function automatic logic [BITSTREAM-1:0] rot_left(
        input logic [BITSTREAM-1:0] x,
        input logic [1:0]           sh
    );
        logic [BITSTREAM-1:0] r;
        r = x;
        case (sh)
            2'd0: r = x;
            2'd1: r = {x[BITSTREAM-2:0], x[BITSTREAM-1]};
            2'd2: r = {x[BITSTREAM-3:0], x[BITSTREAM-1:BITSTREAM-2]};
            2'd3: r = {x[BITSTREAM-4:0], x[BITSTREAM-1:BITSTREAM-3]};
        endcase
        return r;
    endfunction

`ifdef K_PHASE_BIDIR_EN
    function automatic logic [BITSTREAM-1:0] rot_right(
        input logic [BITSTREAM-1:0] x,
        input logic [1:0]           sh
    );
        logic [BITSTREAM-1:0] r;
        r = x;
        case (sh)
            2'd0: r = x;
            2'd1: r = {x[0],   x[BITSTREAM-1:1]};
            2'd2: r = {x[1:0], x[BITSTREAM-1:2]};
            2'd3: r = {x[2:0], x[BITSTREAM-1:3]};
        endcase
        return r;
    endfunction
`endif

    logic [BITSTREAM-1:0] w_rot_p0;
    logic [BITSTREAM-1:0] r_bits_p1;
    logic                 r_vld_p1;

    // Stage p0: select one of the fixed rotations
    always_comb begin
        w_rot_p0 = rot_left(in_bits, k);
`ifdef K_PHASE_BIDIR_EN
        if (dir) begin
            w_rot_p0 = rot_right(in_bits, k);
        end
`endif
    end

    // Stage p1: output register; data holds while input is idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_bits_p1 <= '0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_bits_p1 <= w_rot_p0;
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign out_bits  = r_bits_p1;

endmodule

// File: tb/tb_k_phase_2b.sv
// Directed-vector and random bench for the k_phase_2b bitstream rotator at BITSTREAM=64.
module tb_k_phase_2b;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   k;
    logic [W-1:0] in_bits;
    logic         dir;
    logic         out_valid;
    logic [W-1:0] out_bits;

    int n_total;
    int n_pass;

    k_phase_2b #(.BITSTREAM(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .k        (k),
        .in_bits  (in_bits),
`ifdef K_PHASE_BIDIR_EN
        .dir      (dir),
`endif
        .out_valid(out_valid),
        .out_bits (out_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   k;
        logic [W-1:0] din;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    // Bit-index reference: out[i] = in[(i-k) mod W] (left) or in[(i+k) mod W] (right)
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input int sh, input logic right);
        logic [W-1:0] o;
        for (int i = 0; i < W; i++) begin
            if (right) o[i] = x[(i + sh) % W];
            else       o[i] = x[(i - sh + W) % W];
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [W-1:0] hold;
        logic [W-1:0] e;
        logic         iv;
        n_total  = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        k        = 2'd0;
        dir      = 1'b0;
        in_bits  = '1;

        vecs[0] = '{2'd0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        vecs[1] = '{2'd1, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0003};
        vecs[2] = '{2'd3, 64'hF000_0000_0000_0000, 64'h8000_0000_0000_0007};
        vecs[3] = '{2'd2, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0006};
        vecs[4] = '{2'd2, 64'hC000_0000_0000_0000, 64'h0000_0000_0000_0003};
        vecs[5] = '{2'd3, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0008};
        vecs[6] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{2'd0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        vecs[8] = '{2'd1, 64'hF000_0000_0000_0000, 64'hE000_0000_0000_0001};
        vecs[9] = '{2'd2, 64'h1234_5678_9ABC_DEF0, 64'h48D1_59E2_6AF3_7BC0};

        // Reset held two cycles with valid all-ones input
        tick();
        check("rst1_valid", {63'd0, out_valid}, 64'd0);
        check("rst1_bits", out_bits, 64'd0);
        tick();
        check("rst2_valid", {63'd0, out_valid}, 64'd0);
        check("rst2_bits", out_bits, 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            k        = vecs[v].k;
            in_bits  = vecs[v].din;
            in_valid = 1'b1;
            tick();
            check($sformatf("vec%0d_valid", v), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_bits", v), out_bits, vecs[v].exp);
        end

        // Idle cycle: valid drops, data holds the last word
        in_valid = 1'b0;
        in_bits  = 64'hAAAA_AAAA_AAAA_AAAA;
        k        = 2'd1;
        tick();
        check("idle_valid", {63'd0, out_valid}, 64'd0);
        check("idle_hold", out_bits, 64'h48D1_59E2_6AF3_7BC0);

        // Back-to-back words with k changing every cycle
        in_valid = 1'b1;
        k = 2'd2; in_bits = 64'h1;
        tick();
        check("b2b_0", out_bits, 64'h4);
        k = 2'd1; in_bits = 64'h1;
        tick();
        check("b2b_1", out_bits, 64'h2);
        check("b2b_valid", {63'd0, out_valid}, 64'd1);

        // Mid-stream reset drops the in-flight word
        rst_n = 1'b0; k = 2'd3; in_bits = 64'h5;
        tick();
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_bits", out_bits, 64'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        check("post_rst_idle", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b1; k = 2'd1; in_bits = 64'h8000_0000_0000_0000;
        tick();
        check("post_rst_first_valid", {63'd0, out_valid}, 64'd1);
        check("post_rst_first_bits", out_bits, 64'h1);
        hold = 64'h1;

`ifdef K_PHASE_BIDIR_EN
        dir = 1'b1; k = 2'd1; in_bits = 64'h1;
        tick();
        check("bidir_r1", out_bits, 64'h8000_0000_0000_0000);
        dir = 1'b1; k = 2'd3; in_bits = 64'h8;
        tick();
        check("bidir_r3", out_bits, 64'h1);
        hold = 64'h1;
        dir = 1'b0;
`endif

        // Random stream: model, popcount and valid tracking
        for (int c = 0; c < 1000; c++) begin
            logic rd;
            iv       = 1'($urandom_range(0, 1));
            in_valid = iv;
            k        = 2'($urandom_range(0, 3));
            in_bits  = {$urandom, $urandom};
`ifdef K_PHASE_BIDIR_EN
            dir = 1'($urandom_range(0, 1));
            rd  = dir;
`else
            rd  = 1'b0;
`endif
            e = model(in_bits, int'(k), rd);
            tick();
            check("rand_valid", {63'd0, out_valid}, {63'd0, iv});
            if (iv) begin
                hold = e;
                check("rand_popcount", 64'($countones(out_bits)), 64'($countones(e)));
            end
            check("rand_bits", out_bits, hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
